// File: rtl/inst_mem_ctrl.sv
// inst_mem_ctrl: synchronous-read instruction memory for the IF stage.
// Registered fetch port with stall hold and address-fault substitution,
// plus an optional streaming program-load port.
// Build option: define INSTMEM_LOAD_EN to build the load port and its
// RUN/DRAIN/LOAD state machine; otherwise the memory is read-only.
// reset is asynchronous and active-low.
module inst_mem_ctrl #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 512,
  parameter int                AW       = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_addr,
  input  logic              stall,
  output logic              fetch_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] instruction,
  output logic              inst_fault,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic [AW:0]       ld_count,
  output logic              busy
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     rd_idx;
  logic              addr_fault;
  logic              fetch_take;
  logic              drain;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign rd_idx     = fetch_addr[AW+1:2];
  // Misaligned PC or any set bit above the word-index field.
  assign addr_fault = (|fetch_addr[1:0]) | ((fetch_addr >> (AW+2)) != '0);
  assign fetch_take = fetch_ready & fetch_valid & ~stall;

  // Fetch output register: 1-cycle read, held under stall, cleared by DRAIN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction <= NOP_WORD;
      inst_valid  <= 1'b0;
      inst_fault  <= 1'b0;
    end else if (drain) begin
      inst_valid <= 1'b0;
    end else if (!stall) begin
      inst_valid <= fetch_take;
      if (fetch_take) begin
        inst_fault  <= addr_fault;
        instruction <= addr_fault ? NOP_WORD : mem[rd_idx];
      end
    end
  end

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

`ifdef INSTMEM_LOAD_EN
  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t      state, state_nxt;
  logic [AW:0] wr_cnt;
  logic        beat;

  // State register; an asynchronous reset aborts any load in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt   = state;
    fetch_ready = 1'b0;
    ld_ready    = 1'b0;
    busy        = 1'b0;
    case (state)
      RUN: begin
        fetch_ready = 1'b1;
        if (ld_start) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        ld_ready = 1'b1;
        if (ld_valid && ld_last) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign beat  = ld_ready & ld_valid;
  assign drain = (state == DRAIN);

  // Write pointer doubles as ld_count; saturates at DEPTH so beats past the
  // end are accepted but never wrap onto low addresses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt <= '0;
    end else if (drain) begin
      wr_cnt <= '0;
    end else if (beat && (wr_cnt != FULL)) begin
      wr_cnt <= wr_cnt + 1'b1;
    end
  end

  assign mem_we    = beat && (wr_cnt != FULL);
  assign mem_waddr = wr_cnt[AW-1:0];
  assign mem_wdata = ld_data;
  assign ld_count  = wr_cnt;
`else
  logic unused_ld;

  assign fetch_ready = 1'b1;
  assign ld_ready    = 1'b0;
  assign busy        = 1'b0;
  assign ld_count    = '0;
  assign drain       = 1'b0;
  assign mem_we      = 1'b0;
  assign mem_waddr   = '0;
  assign mem_wdata   = '0;
  assign unused_ld   = ^{ld_start, ld_valid, ld_last, ld_data};
`endif

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Self-checking bench for inst_mem_ctrl: a behavioural model (array memory,
// mode number, plain arithmetic address checks) compared every cycle, plus
// directed vectors with hand-computed literal expectations.
module tb_inst_mem_ctrl;

  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam logic [31:0] NOP = 32'h00000000;

  logic        clk;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        stall;
  logic        fetch_ready;
  logic        inst_valid;
  logic [31:0] instruction;
  logic        inst_fault;
  logic        ld_start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [AW:0] ld_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  inst_mem_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .stall(stall),
    .fetch_ready(fetch_ready), .inst_valid(inst_valid),
    .instruction(instruction), .inst_fault(inst_fault),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .ld_count(ld_count), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = running, 1 = one drain cycle, 2 = accepting load words
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  int          m_mode  = 0;
  int          m_cnt   = 0;
  logic [31:0] m_instr = NOP;
  bit          m_valid = 0;
  bit          m_fault = 0;
  bit          m_ikn   = 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode  <= 0;
      m_cnt   <= 0;
      m_instr <= NOP;
      m_valid <= 0;
      m_fault <= 0;
      m_ikn   <= 1;
    end else begin
      if (m_mode == 1) begin
        m_valid <= 0;
      end else if (!stall) begin
        if (m_mode == 0 && fetch_valid) begin
          m_valid <= 1;
          if ((fetch_addr % 4) != 0 || fetch_addr >= 32'(DEPTH * 4)) begin
            m_fault <= 1;
            m_instr <= NOP;
            m_ikn   <= 1;
          end else begin
            m_fault <= 0;
            m_instr <= m_mem[fetch_addr / 4];
            m_ikn   <= m_known[fetch_addr / 4];
          end
        end else begin
          m_valid <= 0;
        end
      end
`ifdef INSTMEM_LOAD_EN
      if (m_mode == 0 && ld_start) begin
        m_mode <= 1;
      end else if (m_mode == 1) begin
        m_mode <= 2;
        m_cnt  <= 0;
      end else if (m_mode == 2 && ld_valid) begin
        if (m_cnt < DEPTH) begin
          m_mem[m_cnt]   <= ld_data;
          m_known[m_cnt] <= 1;
          m_cnt          <= m_cnt + 1;
        end
        if (ld_last) m_mode <= 0;
      end
`endif
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_inst_valid", inst_valid, m_valid);
    chk("cyc_inst_fault", inst_fault, m_fault);
    if (m_ikn) chk("cyc_instruction", instruction, m_instr);
    chk("cyc_fetch_ready", fetch_ready, m_mode == 0);
    chk("cyc_ld_ready", ld_ready, m_mode == 2);
    chk("cyc_busy", busy, m_mode != 0);
    chk("cyc_ld_count", ld_count, m_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_valid = 1'b1;
    fetch_addr  = a;
    cyc();
    fetch_valid = 1'b0;
  endtask

  function automatic logic [31:0] beat_val(input int kind, input int i);
    if (kind == 0) return (i == 0) ? 32'h24040029 : (32'hC0000000 | 32'(i));
    if (kind == 1) return 32'hA0 + 32'(i);
    return 32'hB0 + 32'(i);
  endfunction

  // Starts a load (optionally together with a fetch), then streams n words.
  // Returns early, still in load mode, when abort_at is reached.
  task automatic run_load(input int n, input int kind, input int gap_every,
                          input int abort_at, input bit with_fetch,
                          input logic [31:0] faddr, input logic [31:0] fexp);
    int k;
    ld_start    = 1'b1;
    fetch_valid = with_fetch;
    fetch_addr  = faddr;
    cyc();
    ld_start    = 1'b0;
    fetch_valid = 1'b0;
    if (with_fetch) begin
      chk("start_fetch_valid", inst_valid, 1);
      chk("start_fetch_data", instruction, fexp);
    end
    k = 0;
    while (!ld_ready && k < 8) begin
      cyc();
      k++;
    end
    chk("ld_ready_rise", ld_ready, 1);
    chk("drain_clears_valid", inst_valid, 0);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) return;
      ld_valid = 1'b1;
      ld_data  = beat_val(kind, i);
      ld_last  = (i == n - 1);
      ld_start = (i == 1);
      cyc();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      ld_start = 1'b0;
      if (gap_every != 0 && (i % gap_every) == 0) cyc();
    end
  endtask

  initial begin
    reset = 1'b1; fetch_valid = 1'b0; fetch_addr = '0; stall = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    #1 reset = 1'b0;
    #10;
    chk("rst_instruction", instruction, NOP);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_fault", inst_fault, 0);
    chk("rst_fetch_ready", fetch_ready, 1);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ld_count", ld_count, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc();

`ifdef INSTMEM_LOAD_EN
    // Overlong load: two beats beyond the end must be dropped.
    run_load(DEPTH + 2, 0, 0, -1, 1'b0, '0, '0);
    chk("big_ld_count", ld_count, DEPTH);
    chk("big_busy_fall", busy, 0);
`endif

    fetch(32'h0);
    chk("f0_valid", inst_valid, 1);
    chk("f0_fault", inst_fault, 0);
`ifdef INSTMEM_LOAD_EN
    chk("f0_data", instruction, 32'h24040029);
    fetch(32'h7FC);
    chk("f_last_data", instruction, 32'hC00001FF);
`endif

    // Stall hold: request 0x8, then stall three cycles while PC moves to 0xC.
    fetch(32'h8);
`ifdef INSTMEM_LOAD_EN
    chk("f8_data", instruction, 32'hC0000002);
`endif
    stall = 1'b1; fetch_valid = 1'b1; fetch_addr = 32'hC;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_valid", inst_valid, 1);
      chk("stall_fault", inst_fault, 0);
`ifdef INSTMEM_LOAD_EN
      chk("stall_data", instruction, 32'hC0000002);
`endif
    end
    stall = 1'b0;
    cyc();
    fetch_valid = 1'b0;
    chk("post_stall_valid", inst_valid, 1);
`ifdef INSTMEM_LOAD_EN
    chk("post_stall_data", instruction, 32'hC0000003);
`endif

    // Faults: misaligned and out of range.
    fetch(32'h6);
    chk("f6_data", instruction, NOP);
    chk("f6_fault", inst_fault, 1);
    fetch(32'h800);
    chk("f800_data", instruction, NOP);
    chk("f800_fault", inst_fault, 1);
    cyc();
    chk("idle_valid_drop", inst_valid, 0);
    chk("idle_data_hold", instruction, NOP);

`ifdef INSTMEM_LOAD_EN
    // Small gapped load started in the same cycle as a fetch of 0x4.
    run_load(4, 1, 1, -1, 1'b1, 32'h4, 32'hC0000001);
    chk("small_ld_count", ld_count, 4);
    chk("small_busy_fall", busy, 0);
    for (int i = 0; i < 4; i++) begin
      fetch(32'(i * 4));
      chk("small_fetch", instruction, 32'hA0 + 32'(i));
    end

    // Abort a load by reset after three words.
    run_load(6, 2, 0, 3, 1'b0, '0, '0);
    chk("abort_pre_busy", busy, 1);
    reset = 1'b0;
    #2;
    chk("abort_ld_ready", ld_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_fetch_ready", fetch_ready, 1);
    chk("abort_ld_count", ld_count, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc();
    fetch(32'h0);
    chk("abort_kept_w0", instruction, 32'hB0);
    fetch(32'h8);
    chk("abort_kept_w2", instruction, 32'hB2);
    fetch(32'hC);
    chk("abort_untouched_w3", instruction, 32'hA3);
`else
    // Read-only build: the load port must stay inert.
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 32'hDEADBEEF;
    cyc();
    ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_last = (i == 3);
      cyc();
      chk("ro_ld_ready", ld_ready, 0);
      chk("ro_busy", busy, 0);
      chk("ro_ld_count", ld_count, 0);
      chk("ro_fetch_ready", fetch_ready, 1);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    fetch(32'h4);
    chk("ro_fetch_valid", inst_valid, 1);
    chk("ro_fetch_fault", inst_fault, 0);
`endif

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
